// File: rtl/uart_tx_frame.sv
// UART transmit framer: turns each rising edge of BaudOut into a bit tick and sends
// start, DATA_WIDTH data bits (LSB first), optional parity and 1 or 2 stop bits on a registered TX line.
module uart_tx_frame #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  baud_out_i,
    input  logic                  send_i,
    input  logic [DATA_WIDTH-1:0] data_in_i,
    input  logic [1:0]            parity_type_i,
    input  logic                  stop_bits_i,
    output logic                  data_out_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2,
        S_FINISH
    } state_e;

    state_e                state_q;
    logic                  baud_prev_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  par_en_q;
    logic                  par_bit_q;
    logic                  stop2_q;
    logic                  data_out_q;
    logic                  busy_q;
    logic                  done_q;

    logic                  tick_c;
    logic                  par_en_d;
    logic                  par_bit_d;

    // BaudOut already lives in this clock domain, so a plain edge detect is enough
    assign tick_c    = baud_out_i & ~baud_prev_q;

    // Types 01 (odd) and 10 (even) carry a parity slot; 00 and 11 do not
    assign par_en_d  = parity_type_i[0] ^ parity_type_i[1];
    assign par_bit_d = parity_type_i[0] ? ~(^data_in_i) : (^data_in_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            baud_prev_q <= 1'b0;
            shift_q     <= '0;
            cnt_q       <= '0;
            par_en_q    <= 1'b0;
            par_bit_q   <= 1'b0;
            stop2_q     <= 1'b0;
            data_out_q  <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            baud_prev_q <= baud_out_i;
            done_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    data_out_q <= 1'b1;
                    if (send_i) begin
                        shift_q   <= data_in_i;
                        par_en_q  <= par_en_d;
                        par_bit_q <= par_bit_d;
                        stop2_q   <= stop_bits_i;
                        busy_q    <= 1'b1;
                        state_q   <= S_ARM;
                    end
                end
                // A tick in the acceptance cycle is skipped: the start bit waits for the next one
                S_ARM: begin
                    if (tick_c) begin
                        data_out_q <= 1'b0;
                        state_q    <= S_START;
                    end
                end
                S_START: begin
                    if (tick_c) begin
                        data_out_q <= shift_q[0];
                        shift_q    <= shift_q >> 1;
                        cnt_q      <= CNT_W'(1);
                        state_q    <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (tick_c) begin
                        if (cnt_q < CNT_W'(DATA_WIDTH)) begin
                            data_out_q <= shift_q[0];
                            shift_q    <= shift_q >> 1;
                            cnt_q      <= cnt_q + CNT_W'(1);
                        end else if (par_en_q) begin
                            data_out_q <= par_bit_q;
                            state_q    <= S_PARITY;
                        end else begin
                            data_out_q <= 1'b1;
                            state_q    <= S_STOP1;
                        end
                    end
                end
                S_PARITY: begin
                    if (tick_c) begin
                        data_out_q <= 1'b1;
                        state_q    <= S_STOP1;
                    end
                end
                S_STOP1: begin
                    if (tick_c) begin
                        if (stop2_q) begin
                            data_out_q <= 1'b1;
                            state_q    <= S_STOP2;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= S_FINISH;
                        end
                    end
                end
                S_STOP2: begin
                    if (tick_c) begin
                        done_q  <= 1'b1;
                        state_q <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign data_out_o = data_out_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: BaudOut toggles every 4 clocks (8-clock bit period);
// every TX bit, Busy and Done are compared against hand-written frame images each clock.
module tb_uart_tx_frame;

    localparam int unsigned DW = 8;

    logic          clk       = 1'b0;
    logic          rst       = 1'b0;
    logic          baud;
    logic          send      = 1'b0;
    logic [DW-1:0] data_in   = '0;
    logic [1:0]    ptype     = 2'b00;
    logic          stop_bits = 1'b0;
    logic          data_out;
    logic          busy;
    logic          done;
    logic [2:0]    div       = 3'd0;

    int checks = 0;
    int errors = 0;

    uart_tx_frame #(.DATA_WIDTH(DW)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .baud_out_i    (baud),
        .send_i        (send),
        .data_in_i     (data_in),
        .parity_type_i (ptype),
        .stop_bits_i   (stop_bits),
        .data_out_o    (data_out),
        .busy_o        (busy),
        .done_o        (done)
    );

    always #5 clk = ~clk;

    // Baud generator stand-in: BaudOut rises when div goes 3->4, so the tick is registered on the 4->5 edge
    always @(posedge clk) div <= div + 3'd1;
    assign baud = div[2];

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed {tx,busy,done}=%b expected %b", tag, obs, exp);
        end
    endtask

    // Called at a negedge; raises Send when div==ph, checks the ARM wait, returns at the first start-bit sample
    task automatic send_word(input logic [7:0] d, input logic [1:0] pt, input logic sb, input logic [2:0] ph);
        int w;
        while (div != ph) @(negedge clk);
        chk("idle before send", {data_out, busy, done}, 3'b100);
        data_in   = d;
        ptype     = pt;
        stop_bits = sb;
        send      = 1'b1;
        w = ((3 - int'(ph)) & 7) + 1;
        @(negedge clk);
        send = 1'b0;
        chk("busy after accept", {data_out, busy, done}, 3'b110);
        for (int k = 2; k <= w; k++) begin
            @(negedge clk);
            chk($sformatf("arm wait clk %0d", k), {data_out, busy, done}, 3'b110);
        end
        @(negedge clk);
    endtask

    // Walks nbits slots of 8 clocks each; line[nbits-1] is the start bit
    task automatic run_frame(input logic [11:0] line, input int nbits, input int pulse_at, input int abort_at);
        for (int s = 0; s < nbits * 8; s++) begin
            if (s > 0) @(negedge clk);
            if (s == abort_at) return;
            if (s == pulse_at) begin
                data_in = 8'h81;
                send    = 1'b1;
            end else if (s == pulse_at + 1) begin
                send = 1'b0;
            end
            chk($sformatf("frame slot %0d clk %0d", s / 8, s % 8),
                {data_out, busy, done}, {line[nbits - 1 - s / 8], 1'b1, 1'b0});
        end
        @(negedge clk);
        chk("done pulse", {data_out, busy, done}, 3'b111);
        @(negedge clk);
        chk("idle after done", {data_out, busy, done}, 3'b100);
    endtask

    initial begin
        #2 rst = 1'b1;
        #1 chk("async reset values", {data_out, busy, done}, 3'b100);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle after reset", {data_out, busy, done}, 3'b100);

        // 0xA5 even parity, 1 stop; Send coincides with a tick so the start bit waits a full period
        send_word(8'hA5, 2'b10, 1'b0, 3'd4);
        run_frame(12'b0_0_10100101_0_1, 11, -1, -1);

        // 0x00 odd parity, 2 stop bits
        send_word(8'h00, 2'b01, 1'b1, 3'd1);
        run_frame(12'b0_00000000_1_1_1, 12, -1, -1);

        // 0xFF with type 11: no parity slot, 10 bit periods
        send_word(8'hFF, 2'b11, 1'b0, 3'd7);
        run_frame(12'b00_0_11111111_1, 10, -1, -1);

        // 0x3C with a Send=0x81 pulse mid-frame that must be ignored
        send_word(8'h3C, 2'b00, 1'b0, 3'd0);
        run_frame(12'b00_0_00111100_1, 10, 20, -1);

        // 0x81 sent in the cycle right after Done
        send_word(8'h81, 2'b00, 1'b0, 3'd6);
        run_frame(12'b00_0_10000001_1, 10, -1, -1);

        // Abort 0xA5 during data bit 3 (line low there) with an asynchronous reset
        send_word(8'hA5, 2'b10, 1'b0, 3'd2);
        run_frame(12'b0_0_10100101_0_1, 11, -1, 35);
        rst = 1'b1;
        #1 chk("reset mid-frame", {data_out, busy, done}, 3'b100);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk($sformatf("no done after abort %0d", k), {data_out, busy, done}, 3'b100);
        end

        // 0x55 odd parity, 1 stop after the abort
        send_word(8'h55, 2'b01, 1'b0, 3'd3);
        run_frame(12'b0_0_10101010_1_1, 11, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- Transmit framer directly downstream of the baud rate generator.
- Samples the generator's BaudOut square wave in the system clock domain and derives one bit tick per BaudOut period.
- Serialises a parallel word into an asynchronous UART frame: start bit, data LSB first, optional parity, 1 or 2 stop bits.
- Drives the TX line and a simple Send/Busy/Done handshake toward the host logic.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (5..9 legal).

Ports:
- Clock  in  1  system clock, same clock that drives the baud rate generator.
- Reset  in  1  asynchronous, active-high reset.
- BaudOut  in  1  square wave from the baud rate generator, synchronous to Clock.
- Send  in  1  request strobe; sampled only when Busy=0.
- DataIn  in  DATA_WIDTH  word to transmit; latched on acceptance.
- ParityType  in  2  00=none, 01=odd, 10=even, 11=none; latched on acceptance.
- StopBits  in  1  0=one stop bit, 1=two stop bits; latched on acceptance.
- DataOut  out  1  serial TX line; idle high.
- Busy  out  1  high from the cycle after acceptance until frame completion.
- Done  out  1  one-cycle pulse at frame completion.

Behaviour:
- Clock and reset: one clock (Clock). Reset is asynchronous and active-high.
- Reset values (asynchronous, take effect immediately):
  - DataOut=1, Busy=0, Done=0.
  - State=IDLE, BaudPrev=0, shift register=0, bit counter=0.
- Tick derivation:
  - BaudPrev registers BaudOut every Clock.
  - Tick = BaudOut & ~BaudPrev, i.e. the rising edge of BaudOut.
  - No synchroniser is needed; BaudOut is in the Clock domain.
  - One bit period = one full BaudOut period = 2*(FinalValue+1) clocks.
- Acceptance:
  - In IDLE with Send=1, latch DataIn, ParityType and StopBits.
  - Compute the parity bit: odd = ~^DataIn, even = ^DataIn.
  - Busy=1 from the next cycle; state -> ARM.
  - Send while Busy=1 is ignored. No queuing, no error flag.
- State machine (all transitions occur only on Tick, except IDLE->ARM):
  - IDLE: DataOut=1.
  - ARM: waits for the first Tick after acceptance. A Tick in the acceptance cycle itself is not used. On Tick: DataOut<=0, -> START.
  - START: on Tick, DataOut<=data[0], counter<=1, -> DATA.
  - DATA: on Tick, if counter<DATA_WIDTH, DataOut<=data[counter] and counter++. Otherwise, if parity is enabled, DataOut<=parity and -> PARITY; else DataOut<=1 and -> STOP1.
  - PARITY: on Tick, DataOut<=1, -> STOP1.
  - STOP1: on Tick, if StopBits=1, DataOut<=1 and -> STOP2; else -> FINISH.
  - STOP2: on Tick, -> FINISH.
  - FINISH: one cycle; Done=1, Busy<=0, -> IDLE.
- Each line level holds for exactly one bit period, from Tick to Tick.
- Done is high for exactly one Clock. Busy is 0 in the cycle after Done.
- A new Send may be accepted in the cycle after FINISH; the line stays high until the next Tick.
- Tick-to-DataOut latency is 1 clock (registered output).
- Reset mid-frame: DataOut returns to 1 immediately and the frame is aborted. No Done pulse is produced.
- A BaudRate change in the upstream generator mid-frame is not detected. Bit length follows BaudOut as received.
- DataOut is glitch-free (registered).

Test Plan:
- Setup for all scenarios: bench drives BaudOut toggling every 4 clocks, giving an 8-clock bit period.
- 0xA5, even parity, 1 stop bit -> DataOut sequence 0 | 1 0 1 0 0 1 0 1 | 0 | 1, each bit 8 clocks. Done pulses once. Busy spans acceptance+1 through FINISH.
- 0x00, odd parity, 2 stop bits -> 0 | 0 0 0 0 0 0 0 0 | 1 | 1 1. Done only after the second stop period.
- 0xFF, ParityType=11, 1 stop bit -> 0 | 1×8 | 1, no parity slot; frame length 10 bit periods.
- Send=0x3C, re-pulse Send=0x81 mid-frame -> only the 0x3C frame is transmitted. Send=0x81 in the cycle after Done -> second frame starts at the next Tick.
- Assert Reset during DATA bit 3 -> DataOut=1 and Busy=0 asynchronously, no Done. After release, Send=0x55 yields a correct full frame.
- Send coincident with a Tick in IDLE -> start bit begins at the following Tick, not the coincident one.
